// File: rtl/digit_serial_addsub_if.sv
// rtl/digit_serial_addsub_if.sv - operand/result bundle for digit_serial_addsub; zero present with DIGIT_SERIAL_ZERO_FLAG_EN
interface digit_serial_addsub_if #(
   parameter int DIGIT_W = 1
);
   logic               in_valid;
   logic               first;
   logic               sub;
   logic [DIGIT_W-1:0] a;
   logic [DIGIT_W-1:0] b;
   logic               out_valid;
   logic [DIGIT_W-1:0] sum;
   logic               out_last;
   logic               carry_out;
   logic               overflow;
   logic               frame_err;
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
   logic               zero;
`endif

   modport master (
      output in_valid, first, sub, a, b,
      input  out_valid, sum, out_last, carry_out, overflow, frame_err
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      , input zero
`endif
   );

   modport slave (
      input  in_valid, first, sub, a, b,
      output out_valid, sum, out_last, carry_out, overflow, frame_err
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      , output zero
`endif
   );
endinterface

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial add/sub, LSB digit first, carry held across cycles
// Optional end-of-word zero flag enabled by defining DIGIT_SERIAL_ZERO_FLAG_EN.
module digit_serial_addsub #(
   parameter int DIGIT_W     = 1,
   parameter int WORD_DIGITS = 8,
   parameter int CNT_W       = $clog2(WORD_DIGITS)
) (
   input logic                  clk,
   input logic                  reset,
   digit_serial_addsub_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               carry_q, carry_d;
   logic               mode_q, mode_d;

   logic               sub_mode, cin, c_next, c_msb;
   logic [DIGIT_W-1:0] b_eff, s;
   logic               accept, start, last, ferr;

   logic               out_valid_q, out_last_q, carry_out_q, overflow_q, frame_err_q;
   logic [DIGIT_W-1:0] sum_q;

   // Subtraction is a + ~b + 1, with the +1 injected as carry-in on the first digit.
   always_comb begin
      sub_mode    = bus.first ? bus.sub : mode_q;
      b_eff       = sub_mode ? ~bus.b : bus.b;
      cin         = bus.first ? bus.sub : carry_q;
      {c_next, s} = {1'b0, bus.a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
      c_msb       = bus.a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ s[DIGIT_W-1];
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      carry_d = carry_q;
      mode_d  = mode_q;
      accept  = 1'b0;
      start   = 1'b0;
      last    = 1'b0;
      ferr    = 1'b0;
      if (bus.in_valid) begin
         case (state_q)
            IDLE: begin
               if (bus.first) start = 1'b1;
               else           ferr  = 1'b1;
            end
            RUN: begin
               if (bus.first) begin
                  start = 1'b1;
                  ferr  = 1'b1;
               end else begin
                  accept = 1'b1;
                  if (count_q == LAST_IDX) begin
                     last    = 1'b1;
                     state_d = IDLE;
                     count_d = '0;
                     carry_d = 1'b0;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                     carry_d = c_next;
                  end
               end
            end
            default: ;
         endcase
         // An early first abandons the open word and restarts exactly as from IDLE.
         if (start) begin
            accept  = 1'b1;
            state_d = RUN;
            count_d = CNT_W'(1);
            carry_d = c_next;
            mode_d  = bus.sub;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         carry_q     <= 1'b0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         out_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         out_valid_q <= accept;
         sum_q       <= accept ? s : '0;
         out_last_q  <= last;
         carry_out_q <= last & c_next;
         overflow_q  <= last & (c_msb ^ c_next);
         frame_err_q <= ferr;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.out_last  = out_last_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;

`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
   logic nz_q, zero_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz_q   <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         if (accept) nz_q <= (start ? 1'b0 : nz_q) | (|s);
         zero_q <= last & ~(nz_q | (|s));
      end
   end

   assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - randomized self-checking bench for digit_serial_addsub (1x8 and 4x2 digit configs)
module tb_digit_serial_addsub;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   digit_serial_addsub_if #(.DIGIT_W(1)) bus1 ();
   digit_serial_addsub_if #(.DIGIT_W(4)) bus4 ();

   digit_serial_addsub #(.DIGIT_W(1), .WORD_DIGITS(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   digit_serial_addsub #(.DIGIT_W(4), .WORD_DIGITS(2)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   int checks = 0;
   int failures = 0;

   logic       o_valid, o_last, o_cout, o_ovf, o_ferr, o_zero;
   logic [3:0] o_sum;

   int         w_valid, w_last_cnt, w_last_idx, w_ferr, w_spur, w_stall_valid;
   logic [7:0] w_sum;
   logic       w_cout, w_ovf, w_zero;

   // One clock: drive the selected instance, then sample its registered outputs just after the edge.
   task automatic step(input int sel, input logic v, input logic f, input logic sb,
                       input logic [3:0] da, input logic [3:0] db);
      bus1.in_valid = (sel == 0) && v;
      bus4.in_valid = (sel == 1) && v;
      bus1.first = f; bus4.first = f;
      bus1.sub   = sb; bus4.sub  = sb;
      bus1.a = da[0]; bus1.b = db[0];
      bus4.a = da;    bus4.b = db;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         o_valid = bus1.out_valid; o_sum = {3'b000, bus1.sum}; o_last = bus1.out_last;
         o_cout = bus1.carry_out; o_ovf = bus1.overflow; o_ferr = bus1.frame_err;
      end else begin
         o_valid = bus4.out_valid; o_sum = bus4.sum; o_last = bus4.out_last;
         o_cout = bus4.carry_out; o_ovf = bus4.overflow; o_ferr = bus4.frame_err;
      end
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      o_zero = (sel == 0) ? bus1.zero : bus4.zero;
`else
      o_zero = 1'b0;
`endif
   endtask

   task automatic run_word(input int sel, input logic [7:0] A, input logic [7:0] B, input logic sb,
                           input int stall_at, input int stall_len);
      int dw = (sel == 1) ? 4 : 1;
      int nd = (sel == 1) ? 2 : 8;
      logic [3:0] mask = (sel == 1) ? 4'hF : 4'h1;
      w_valid = 0; w_last_cnt = 0; w_last_idx = -1; w_ferr = 0; w_spur = 0; w_stall_valid = 0;
      w_sum = 8'h00; w_cout = 1'b0; w_ovf = 1'b0; w_zero = 1'b0;
      for (int i = 0; i < nd; i++) begin
         if (i == stall_at) begin
            for (int k = 0; k < stall_len; k++) begin
               step(sel, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
               if (o_valid || o_last) w_stall_valid++;
            end
         end
         step(sel, 1'b1, (i == 0), sb, 4'(A >> (dw * i)) & mask, 4'(B >> (dw * i)) & mask);
         if (o_valid) begin
            w_valid++;
            w_sum = w_sum | (8'(o_sum & mask) << (dw * i));
         end
         if (o_last) begin
            w_last_cnt++; w_last_idx = i; w_cout = o_cout; w_ovf = o_ovf; w_zero = o_zero;
         end else if (o_cout || o_ovf || o_zero) begin
            w_spur++;
         end
         if (o_ferr) w_ferr++;
      end
   endtask

   // Whole-word arithmetic reference: result mod 256, unsigned carry/no-borrow, signed range overflow.
   task automatic ref_word(input logic [7:0] A, input logic [7:0] B, input logic sb,
                           output logic [7:0] r, output logic c, output logic v, output logic z);
      int ua = int'(A);
      int ub = int'(B);
      int sa = (ua > 127) ? ua - 256 : ua;
      int sbv = (ub > 127) ? ub - 256 : ub;
      int sr;
      if (!sb) begin
         r = 8'(ua + ub); c = (ua + ub) > 255; sr = sa + sbv;
      end else begin
         r = 8'(ua - ub); c = (ua >= ub); sr = sa - sbv;
      end
      v = (sr > 127) || (sr < -128);
      z = (r == 8'h00);
   endtask

   task automatic test_reset;
      checks++; if ({bus1.out_valid, bus1.sum, bus1.out_last, bus1.carry_out, bus1.overflow, bus1.frame_err} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs_w1 got=%b exp=0", {bus1.out_valid, bus1.sum, bus1.out_last, bus1.carry_out, bus1.overflow, bus1.frame_err}); end
      checks++; if ({bus4.out_valid, bus4.sum, bus4.out_last, bus4.carry_out, bus4.overflow, bus4.frame_err} !== 9'b0) begin
         failures++; $display("FAIL reset_outputs_w4 got=%b exp=0", {bus4.out_valid, bus4.sum, bus4.out_last, bus4.carry_out, bus4.overflow, bus4.frame_err}); end
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      checks++; if ({bus1.zero, bus4.zero} !== 2'b00) begin failures++; $display("FAIL reset_zero got=%b exp=00", {bus1.zero, bus4.zero}); end
`endif
      @(negedge clk); reset = 1'b0;
      step(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL idle_after_reset out_valid=%b exp=0", o_valid); end
   endtask

   task automatic test_add_serial;
      run_word(0, 8'h5A, 8'h3C, 1'b0, -1, 0);
      checks++; if (w_sum !== 8'h96) begin failures++; $display("FAIL add_sum got=%h exp=96", w_sum); end
      checks++; if (w_last_idx !== 7 || w_last_cnt !== 1) begin failures++; $display("FAIL add_last got idx=%0d cnt=%0d exp idx=7 cnt=1", w_last_idx, w_last_cnt); end
      checks++; if (w_cout !== 1'b0 || w_ovf !== 1'b1) begin failures++; $display("FAIL add_flags got c=%b v=%b exp c=0 v=1", w_cout, w_ovf); end
      checks++; if (w_spur !== 0) begin failures++; $display("FAIL add_flags_early got=%0d exp=0", w_spur); end
   endtask

   task automatic test_sub_digit4;
      run_word(1, 8'h10, 8'h01, 1'b1, -1, 0);
      checks++; if (w_sum !== 8'h0F) begin failures++; $display("FAIL sub1_sum got=%h exp=0f", w_sum); end
      checks++; if (w_cout !== 1'b1 || w_ovf !== 1'b0 || w_last_idx !== 1) begin
         failures++; $display("FAIL sub1_flags got c=%b v=%b idx=%0d exp c=1 v=0 idx=1", w_cout, w_ovf, w_last_idx); end
      run_word(1, 8'h01, 8'h02, 1'b1, -1, 0);
      checks++; if (w_sum !== 8'hFF) begin failures++; $display("FAIL sub2_sum got=%h exp=ff", w_sum); end
      checks++; if (w_cout !== 1'b0 || w_ovf !== 1'b0) begin failures++; $display("FAIL sub2_flags got c=%b v=%b exp c=0 v=0", w_cout, w_ovf); end
   endtask

   task automatic test_back_to_back;
      run_word(0, 8'hFF, 8'h01, 1'b0, 4, 3);
      checks++; if (w_sum !== 8'h00 || w_cout !== 1'b1 || w_ovf !== 1'b0) begin
         failures++; $display("FAIL stall_word got sum=%h c=%b v=%b exp sum=00 c=1 v=0", w_sum, w_cout, w_ovf); end
      checks++; if (w_stall_valid !== 0 || w_valid !== 8) begin
         failures++; $display("FAIL stall_valid got stall=%0d valid=%0d exp stall=0 valid=8", w_stall_valid, w_valid); end
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      checks++; if (w_zero !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b exp=1", w_zero); end
`endif
      run_word(0, 8'h12, 8'h34, 1'b0, -1, 0);
      checks++; if (w_valid !== 8 || w_sum !== 8'h46 || w_last_idx !== 7 || w_ferr !== 0) begin
         failures++; $display("FAIL b2b_word got valid=%0d sum=%h idx=%0d ferr=%0d exp 8/46/7/0", w_valid, w_sum, w_last_idx, w_ferr); end
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
      checks++; if (w_zero !== 1'b0) begin failures++; $display("FAIL b2b_zero got=%b exp=0", w_zero); end
`endif
   endtask

   task automatic test_framing;
      logic [7:0] r; logic c, v, z;
      int old_last;
      step(0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1);
      checks++; if (o_valid !== 1'b0 || o_ferr !== 1'b1) begin
         failures++; $display("FAIL idle_nofirst got valid=%b ferr=%b exp valid=0 ferr=1", o_valid, o_ferr); end
      step(0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      checks++; if (o_ferr !== 1'b0) begin failures++; $display("FAIL ferr_pulse got=%b exp=0", o_ferr); end
      old_last = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 1'b1, (i == 0), 1'b0, 4'h1, 4'h1);
         if (o_last) old_last++;
      end
      run_word(0, 8'hC3, 8'h5A, 1'b1, -1, 0);
      ref_word(8'hC3, 8'h5A, 1'b1, r, c, v, z);
      checks++; if (old_last !== 0 || w_last_cnt !== 1) begin
         failures++; $display("FAIL restart_last got old=%0d new=%0d exp old=0 new=1", old_last, w_last_cnt); end
      checks++; if (w_ferr !== 1) begin failures++; $display("FAIL restart_ferr got=%0d exp=1", w_ferr); end
      checks++; if (w_sum !== r || w_cout !== c || w_ovf !== v) begin
         failures++; $display("FAIL restart_word got %h/%b/%b exp %h/%b/%b", w_sum, w_cout, w_ovf, r, c, v); end
   endtask

   task automatic test_reset_midword;
      logic [7:0] r; logic c, v, z;
      step(0, 1'b1, 1'b1, 1'b0, 4'h1, 4'h1);
      step(0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1);
      step(0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1);
      checks++; if (o_valid !== 1'b1 || o_sum !== 4'h1) begin
         failures++; $display("FAIL pre_reset got valid=%b sum=%h exp valid=1 sum=1", o_valid, o_sum); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({bus1.out_valid, bus1.sum, bus1.out_last, bus1.carry_out, bus1.overflow, bus1.frame_err} !== 6'b0) begin
         failures++; $display("FAIL async_reset got=%b exp=0", {bus1.out_valid, bus1.sum, bus1.out_last, bus1.carry_out, bus1.overflow, bus1.frame_err}); end
      @(posedge clk); #1 reset = 1'b0;
      step(0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0);
      checks++; if (o_ferr !== 1'b1 || o_valid !== 1'b0) begin
         failures++; $display("FAIL post_reset_idle got ferr=%b valid=%b exp ferr=1 valid=0", o_ferr, o_valid); end
      run_word(0, 8'h7F, 8'h01, 1'b0, -1, 0);
      ref_word(8'h7F, 8'h01, 1'b0, r, c, v, z);
      checks++; if (w_sum !== r || w_cout !== c || w_ovf !== v || w_last_idx !== 7) begin
         failures++; $display("FAIL post_reset_word got %h/%b/%b idx=%0d exp %h/%b/%b idx=7", w_sum, w_cout, w_ovf, w_last_idx, r, c, v); end
   endtask

   task automatic test_random;
      logic [7:0] A, B, r; logic sb, c, v, z;
      int sel, nd;
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 1));
         nd = (sel == 1) ? 2 : 8;
         A = 8'($urandom); B = 8'($urandom); sb = 1'($urandom);
         if (n % 7 == 0) B = sb ? A : 8'(-A);
         run_word(sel, A, B, sb, int'($urandom_range(0, nd)), int'($urandom_range(1, 3)));
         ref_word(A, B, sb, r, c, v, z);
         checks++; if (w_sum !== r) begin failures++; $display("FAIL rnd_sum sel=%0d %h %s %h got=%h exp=%h", sel, A, sb ? "-" : "+", B, w_sum, r); end
         checks++; if (w_cout !== c || w_ovf !== v) begin
            failures++; $display("FAIL rnd_flags sel=%0d %h %s %h got c=%b v=%b exp c=%b v=%b", sel, A, sb ? "-" : "+", B, w_cout, w_ovf, c, v); end
         checks++; if (w_valid !== nd || w_last_cnt !== 1 || w_last_idx !== nd - 1) begin
            failures++; $display("FAIL rnd_framing got valid=%0d last=%0d idx=%0d exp %0d/1/%0d", w_valid, w_last_cnt, w_last_idx, nd, nd - 1); end
         checks++; if (w_stall_valid !== 0 || w_spur !== 0 || w_ferr !== 0) begin
            failures++; $display("FAIL rnd_spurious got stall=%0d spur=%0d ferr=%0d exp 0/0/0", w_stall_valid, w_spur, w_ferr); end
`ifdef DIGIT_SERIAL_ZERO_FLAG_EN
         checks++; if (w_zero !== z) begin failures++; $display("FAIL rnd_zero got=%b exp=%b", w_zero, z); end
`endif
      end
   endtask

   initial begin
      reset = 1'b1;
      bus1.in_valid = 1'b0; bus1.first = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
      bus4.in_valid = 1'b0; bus4.first = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_add_serial;
      test_sub_digit4;
      test_back_to_back;
      test_framing;
      test_reset_midword;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
